// File: rtl/load_store_unit.sv
// Load/store unit: multicycle data-memory access engine fed by the ALU result.
//
// Each accepted request issues at most one memory transaction. Sizes and
// signedness follow RV32I funct3. Store data is replicated across byte lanes,
// and byte strobes select the lanes that are written. Load data is shifted down
// and then sign- or zero-extended. A misaligned access or an illegal funct3
// skips the memory and completes at once with fault=1.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   start               one-cycle request pulse, ignored unless idle
//   is_store, funct3    access type and RV32I size/sign field
//   addr, wdata         effective address and store data
//   busy                memory transaction in progress
//   done, fault         one-cycle completion pulse, fault qualifies done
//   rdata               extended load result, held until the next good load
//   mem_req .. mem_wdata  memory request, held until mem_ready
//   mem_ready, mem_rdata  single-cycle memory accept/complete and read word
module load_store_unit #(
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic [31:0]               rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_wstrb,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ready,
  input  logic [31:0]               mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      fault_q, fault_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]                mem_wstrb_q, mem_wstrb_d;
  logic [31:0]               mem_wdata_q, mem_wdata_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                off_q, off_d;

  logic                      req_fault;
  logic [3:0]                lane_strb;
  logic [31:0]               lane_wdata;
  logic [31:0]               word_addr;
  logic [31:0]               shifted;
  logic [31:0]               load_val;

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    req_fault  = 1'b0;
    lane_strb  = 4'b1111;
    lane_wdata = wdata;
    word_addr  = {addr[31:2], 2'b00};

    case (funct3)
      3'b000:         req_fault = 1'b0;
      3'b001:         req_fault = addr[0];
      3'b010:         req_fault = (addr[1:0] != 2'b00);
      3'b100:         req_fault = is_store;
      3'b101:         req_fault = is_store | addr[0];
      default:        req_fault = 1'b1;
    endcase

    case (funct3[1:0])
      2'b00: begin
        lane_strb  = 4'b0001 << addr[1:0];
        lane_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_strb  = 4'b0011 << addr[1:0];
        lane_wdata = {2{wdata[15:0]}};
      end
      default: begin
        lane_strb  = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  // Load extraction uses the size and offset latched at request time.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          funct3_d = funct3;
          off_d    = addr[1:0];
          if (req_fault) begin
            state_d = StFin;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d     = StReq;
            busy_d      = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = word_addr[MEM_ADDR_WIDTH-1:0];
            mem_wstrb_d = is_store ? lane_strb : 4'b0000;
            mem_wdata_d = is_store ? lane_wdata : 32'h0;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            rdata_d = load_val;
          end
          state_d     = StFin;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0;
        end
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b0;
        fault_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic        fault;
    logic [31:0] maddr;
    logic [3:0]  wstrb;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    start    = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    issue(v.st, v.f3, v.addr, v.wdata);
    @(negedge clk);
    start = 1'b0;
    if (v.fault) begin
      check({tag, ".done"}, {31'b0, done}, 32'd1);
      check({tag, ".fault"}, {31'b0, fault}, 32'd1);
      check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
      check({tag, ".busy"}, {31'b0, busy}, 32'd0);
      check({tag, ".rdata"}, rdata, exp_rd);
      @(negedge clk);
      check({tag, ".done_clr"}, {31'b0, done}, 32'd0);
      check({tag, ".fault_clr"}, {31'b0, fault}, 32'd0);
    end else begin
      check({tag, ".busy"}, {31'b0, busy}, 32'd1);
      check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
      check({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, v.st});
      check({tag, ".mem_addr"}, mem_addr, v.maddr);
      check({tag, ".mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, v.wstrb});
      check({tag, ".mem_wdata"}, mem_wdata, v.mwdata);
      check({tag, ".done_early"}, {31'b0, done}, 32'd0);
      for (int k = 0; k < v.delay; k++) begin
        @(negedge clk);
        check({tag, ".req_hold"}, {31'b0, mem_req}, 32'd1);
        check({tag, ".addr_hold"}, mem_addr, v.maddr);
      end
      mem_ready = 1'b1;
      mem_rdata = v.mrdata;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (!v.st) exp_rd = v.rdata;
      check({tag, ".done"}, {31'b0, done}, 32'd1);
      check({tag, ".fault"}, {31'b0, fault}, 32'd0);
      check({tag, ".busy_fin"}, {31'b0, busy}, 32'd0);
      check({tag, ".req_drop"}, {31'b0, mem_req}, 32'd0);
      check({tag, ".rdata"}, rdata, exp_rd);
      @(negedge clk);
      check({tag, ".done_clr"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    //          st  f3      addr       wdata        mrdata      dly flt maddr      strb     mwdata       rdata
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 3'b000, 32'h102, 32'h000000A5, 32'h0,        1, 1'b0, 32'h100, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vecs[4]  = '{1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0,        0, 1'b0, 32'h200, 4'b1100, 32'h12341234, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 3'b100, 32'h200, 32'hFF,       32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[8]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00008001};
    vecs[9]  = '{1'b1, 3'b010, 32'h30C, 32'hCAFEF00D, 32'h0,        3, 1'b0, 32'h30C, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 0, 1'b0, 32'h000, 4'b0000, 32'h0,        32'h0000007F};
    vecs[13] = '{1'b1, 3'b000, 32'h003, 32'h12345678, 32'h0,        0, 1'b0, 32'h000, 4'b1000, 32'h78787878, 32'h0};
    vecs[14] = '{1'b1, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 3'b101, 32'h100, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};

    resetn    = 1'b0;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    exp_rd    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.fault", {31'b0, fault}, 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.mem_req", {31'b0, mem_req}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // mem_ready while idle must not complete anything.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check("idle_ready.done", {31'b0, done}, 32'd0);
    check("idle_ready.rdata", rdata, exp_rd);
    check("idle_ready.mem_req", {31'b0, mem_req}, 32'd0);

    // start while busy, and start in the completion cycle, are both ignored.
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    issue(1'b1, 3'b010, 32'h500, 32'h55555555);
    @(negedge clk);
    start = 1'b0;
    check("busy_start.mem_addr", mem_addr, 32'h400);
    check("busy_start.mem_we", {31'b0, mem_we}, 32'd0);
    check("busy_start.mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_ready = 1'b0;
    exp_rd = 32'h11223344;
    check("busy_start.done", {31'b0, done}, 32'd1);
    check("busy_start.rdata", rdata, exp_rd);
    issue(1'b0, 3'b010, 32'h600, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("fin_start.mem_req", {31'b0, mem_req}, 32'd0);
    check("fin_start.busy", {31'b0, busy}, 32'd0);
    check("fin_start.done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("fin_start.mem_req2", {31'b0, mem_req}, 32'd0);

    // Reset in the middle of a request abandons it without a done pulse.
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    @(negedge clk);
    start = 1'b0;
    check("mid_rst.req_before", {31'b0, mem_req}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_rd = 32'h0;
    check("mid_rst.mem_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst.busy", {31'b0, busy}, 32'd0);
    check("mid_rst.done", {31'b0, done}, 32'd0);
    check("mid_rst.rdata", rdata, exp_rd);
    @(negedge clk);
    check("mid_rst.done_after", {31'b0, done}, 32'd0);
    run_vec(99, '{1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, 1'b0, 32'h104, 4'b0000,
                  32'h0, 32'h0BADF00D});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
